// File: rtl/rede_float_pkg.sv
// Shared constants and types for the rede_float sample feeder.
// Holds the sample/request widths, the "advance" request code,
// the feeder state encoding and a signed sample type.
package rede_float_pkg;

    localparam int DATA_W = 19;
    localparam int REQ_W  = 4;

    localparam logic [REQ_W-1:0] REQ_CODE = 4'd1;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        RUN     = 2'd2,
        STARVED = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/rede_float_fifo.sv
// Synchronous sample FIFO for the rede_float feeder.
// The head entry is presented combinationally.
// A push into an empty FIFO is not visible to a pop on the same edge.
// Pointers wrap modulo DEPTH (DEPTH must be a power of two).
module rede_float_fifo
    import rede_float_pkg::*;
#(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   LVL_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Storage array; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rede_float_feeder.sv
// Pull-style sample source for rede_float.
// Buffers upstream valid/ready samples in a FIFO and advances the
// registered `sample` output by one on every REQ_CODE request.
// Optional statistics counters are enabled by defining REDE_FEEDER_STATS_EN.
module rede_float_feeder #(
    parameter int                DATA_W   = rede_float_pkg::DATA_W,
    parameter int                DEPTH    = 16,
    parameter int                REQ_W    = rede_float_pkg::REQ_W,
    parameter logic [REQ_W-1:0]  REQ_CODE = rede_float_pkg::REQ_CODE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DATA_W-1:0]   s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [REQ_W-1:0]           req_in,
    output logic signed [DATA_W-1:0]   sample,
    output logic                       sample_vld,
    output logic                       underflow,
    output logic [$clog2(DEPTH):0]     level
`ifdef REDE_FEEDER_STATS_EN
    ,
    output logic [31:0]                served_cnt,
    output logic [15:0]                underflow_cnt
`endif
);

    import rede_float_pkg::*;

    localparam int LEVEL_W = $clog2(DEPTH) + 1;
    localparam logic [LEVEL_W-1:0] DEPTH_LVL = DEPTH[LEVEL_W-1:0];

    feeder_state_t     state;
    feeder_state_t     next_state;
    logic              push;
    logic              pop;
    logic              starve;
    logic              is_req;
    logic              empty;
    logic [DATA_W-1:0] fifo_head;

    assign s_ready = (level < DEPTH_LVL);
    assign push    = s_valid && s_ready;
    assign is_req  = (req_in == REQ_CODE);
    assign empty   = (level == '0);

    rede_float_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (s_data),
        .pop       (pop),
        .head      (fifo_head),
        .level     (level)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision, always based on the occupancy before the edge
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty) next_state = PRIME;
            PRIME:   next_state = RUN;
            RUN:     if (is_req && empty) next_state = STARVED;
            STARVED: if (!empty) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Pop and starvation strobes; STARVED serves its single pending request on arrival
    always_comb begin
        pop    = 1'b0;
        starve = 1'b0;
        case (state)
            PRIME: pop = 1'b1;
            RUN: begin
                if (is_req) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        starve = 1'b1;
                    end
                end
            end
            STARVED: pop = !empty;
            default: begin
                pop    = 1'b0;
                starve = 1'b0;
            end
        endcase
    end

    // Presented sample and status flags; sample holds its value while starved
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample     <= '0;
            sample_vld <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (pop) begin
                sample     <= fifo_head;
                sample_vld <= 1'b1;
            end else if (starve) begin
                sample_vld <= 1'b0;
                underflow  <= 1'b1;
            end
        end
    end

`ifdef REDE_FEEDER_STATS_EN
    // Served-sample and starvation-event counters; the latter saturates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            served_cnt    <= '0;
            underflow_cnt <= '0;
        end else begin
            if (pop) begin
                served_cnt <= served_cnt + 32'd1;
            end
            if (starve && (underflow_cnt != 16'hFFFF)) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rede_float_feeder.sv
// Self-checking bench for rede_float_feeder.
// Accepted samples go into a scoreboard queue when they are driven and are
// popped and compared against `sample` when the feeder serves them.
// Define REDE_FEEDER_STATS_EN to also exercise the statistics counters.
module tb_rede_float_feeder;

    import rede_float_pkg::*;

    localparam int DEPTH   = 16;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic signed [DATA_W-1:0]  s_data;
    logic                      s_valid;
    logic                      s_ready;
    logic [REQ_W-1:0]          req_in;
    logic signed [DATA_W-1:0]  sample;
    logic                      sample_vld;
    logic                      underflow;
    logic [LEVEL_W-1:0]        level;
`ifdef REDE_FEEDER_STATS_EN
    logic [31:0]               served_cnt;
    logic [15:0]               underflow_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard of accepted samples still inside the FIFO, plus expected outputs
    int            sb_q[$];
    int            exp_sample;
    bit            exp_vld;
    bit            exp_uf;
    feeder_state_t exp_state;
    int            exp_served;
    int            exp_ufcnt;

    rede_float_feeder #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .req_in     (req_in),
        .sample     (sample),
        .sample_vld (sample_vld),
        .underflow  (underflow),
        .level      (level)
`ifdef REDE_FEEDER_STATS_EN
        ,
        .served_cnt    (served_cnt),
        .underflow_cnt (underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges the run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check, reports every mismatch
    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Clear the expected view the same way an asynchronous reset clears the feeder
    task automatic model_reset();
        sb_q.delete();
        exp_sample = 0;
        exp_vld    = 1'b0;
        exp_uf     = 1'b0;
        exp_state  = IDLE;
        exp_served = 0;
        exp_ufcnt  = 0;
    endtask

    // Compare every visible output against the expected view
    task automatic check_all(input string tag);
        checkOutput({tag, "/sample"}, sample, exp_sample);
        checkOutput({tag, "/vld"}, int'(sample_vld), int'(exp_vld));
        checkOutput({tag, "/underflow"}, int'(underflow), int'(exp_uf));
        checkOutput({tag, "/level"}, int'(level), sb_q.size());
        checkOutput({tag, "/s_ready"}, int'(s_ready), (sb_q.size() < DEPTH) ? 1 : 0);
`ifdef REDE_FEEDER_STATS_EN
        checkOutput({tag, "/served_cnt"}, int'(served_cnt), exp_served);
        checkOutput({tag, "/underflow_cnt"}, int'(underflow_cnt), exp_ufcnt);
`endif
    endtask

    // Check the asynchronous reset values with no clock edge involved
    task automatic check_reset_values(input string tag);
        checkOutput({tag, "/sample"}, sample, 0);
        checkOutput({tag, "/vld"}, int'(sample_vld), 0);
        checkOutput({tag, "/underflow"}, int'(underflow), 0);
        checkOutput({tag, "/level"}, int'(level), 0);
        checkOutput({tag, "/s_ready"}, int'(s_ready), 1);
`ifdef REDE_FEEDER_STATS_EN
        checkOutput({tag, "/served_cnt"}, int'(served_cnt), 0);
        checkOutput({tag, "/underflow_cnt"}, int'(underflow_cnt), 0);
`endif
    endtask

    // One clock of stimulus: drive, take the edge, advance the expected view, check
    task automatic applyStimulus(input bit valid, input int data,
                                 input logic [REQ_W-1:0] req, input string tag);
        int pre_level;
        bit do_push;
        bit do_pop;
        s_valid = valid;
        s_data  = data[DATA_W-1:0];
        req_in  = req;
        @(posedge clk);
        pre_level = sb_q.size();
        do_push   = valid && (pre_level < DEPTH);
        do_pop    = 1'b0;
        case (exp_state)
            IDLE: begin
                if (pre_level != 0) exp_state = PRIME;
            end
            PRIME: begin
                do_pop    = 1'b1;
                exp_state = RUN;
            end
            RUN: begin
                if (req == 4'd1) begin
                    if (pre_level != 0) begin
                        do_pop = 1'b1;
                    end else begin
                        exp_uf    = 1'b1;
                        exp_vld   = 1'b0;
                        exp_state = STARVED;
                        if (exp_ufcnt < 65535) exp_ufcnt++;
                    end
                end
            end
            STARVED: begin
                if (pre_level != 0) begin
                    do_pop    = 1'b1;
                    exp_state = RUN;
                end
            end
            default: exp_state = IDLE;
        endcase
        if (do_pop) begin
            exp_sample = sb_q.pop_front();
            exp_vld    = 1'b1;
            exp_served++;
        end
        if (do_push) begin
            sb_q.push_back(data);
        end
        #1;
        s_valid = 1'b0;
        req_in  = '0;
        check_all(tag);
    endtask

    initial begin
        int vals[5];
        int v;
        s_valid = 1'b0;
        s_data  = '0;
        req_in  = '0;
        model_reset();

        // Reset is held from time zero; outputs must already be at reset values
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Five pushes with no requests; first sample appears two edges after the first push
        vals = '{100, -200, 300, -400, 500};
        applyStimulus(1'b1, vals[0], 4'd0, "s1_push0");
        applyStimulus(1'b1, vals[1], 4'd0, "s1_push1");
        checkOutput("s1_not_yet_valid", int'(sample_vld), 0);
        applyStimulus(1'b1, vals[2], 4'd0, "s1_push2");
        checkOutput("s1_first_sample", sample, 100);
        applyStimulus(1'b1, vals[3], 4'd0, "s1_push3");
        applyStimulus(1'b1, vals[4], 4'd0, "s1_push4");
        applyStimulus(1'b0, 0, 4'd0, "s1_idle");
        checkOutput("s1_level", int'(level), 4);
        checkOutput("s1_vld", int'(sample_vld), 1);

        // Four back-to-back requests step through the remaining samples
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 0, 4'd1, $sformatf("s2_req%0d", i));
        end
        checkOutput("s2_last_sample", sample, 500);
        checkOutput("s2_level_empty", int'(level), 0);
        checkOutput("s2_no_underflow", int'(underflow), 0);

        // Request on an empty FIFO starves; a single push then satisfies it
        applyStimulus(1'b0, 0, 4'd1, "s3_starve");
        checkOutput("s3_underflow", int'(underflow), 1);
        checkOutput("s3_hold_sample", sample, 500);
        checkOutput("s3_vld_drop", int'(sample_vld), 0);
        applyStimulus(1'b1, 7, 4'd0, "s3_push7");
        applyStimulus(1'b0, 0, 4'd0, "s3_recover");
        checkOutput("s3_recovered_sample", sample, 7);
        checkOutput("s3_recovered_vld", int'(sample_vld), 1);
`ifdef REDE_FEEDER_STATS_EN
        checkOutput("s3_served_total", int'(served_cnt), 6);
        checkOutput("s3_underflow_total", int'(underflow_cnt), 1);
`endif

        // Overfill by two; the excess must be refused, then drain across the pointer wrap
        for (int i = 0; i < DEPTH + 2; i++) begin
            v = (i % 2 == 1) ? -(i * 37 + 11) : (i * 37 + 11);
            applyStimulus(1'b1, v, 4'd0, $sformatf("s4_fill%0d", i));
        end
        checkOutput("s4_full_level", int'(level), DEPTH);
        checkOutput("s4_full_not_ready", int'(s_ready), 0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 0, 4'd1, $sformatf("s4_drain%0d", i));
        end
        checkOutput("s4_last_drained", sample, -(15 * 37 + 11));

        // Non-advance request codes must never pop
        applyStimulus(1'b1, 1234, 4'd0, "s5_push0");
        applyStimulus(1'b1, -4321, 4'd0, "s5_push1");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 0, 4'd2, $sformatf("s5_req2_%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 0, 4'd0, $sformatf("s5_req0_%0d", i));
        end
        checkOutput("s5_level_kept", int'(level), 2);
        checkOutput("s5_sample_kept", sample, -(15 * 37 + 11));
        applyStimulus(1'b0, 0, 4'd1, "s5_real_req");
        checkOutput("s5_real_req_sample", sample, 1234);

        // Mid-stream reset with a push and request on the wires: clears at once, no edge needed
        s_valid = 1'b1;
        s_data  = 19'sd55;
        req_in  = 4'd1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_values("midreset");
        s_valid = 1'b0;
        req_in  = '0;
        @(posedge clk);
        #1;
        check_reset_values("midreset_held");
        rst = 1'b1;

        // The feeder must start cleanly again after reset
        applyStimulus(1'b1, -9, 4'd0, "s6_push");
        applyStimulus(1'b0, 0, 4'd0, "s6_prime");
        applyStimulus(1'b0, 0, 4'd0, "s6_serve");
        checkOutput("s6_sample", sample, -9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
